// File: rtl/alu_pkg.sv
// Shared ALU definitions: sel encodings used by the ALU control decoder and the
// execute-stage FSM state type.
package alu_pkg;

  localparam logic [3:0] SelAnd = 4'b0000;
  localparam logic [3:0] SelOr  = 4'b0001;
  localparam logic [3:0] SelAdd = 4'b0010;
  localparam logic [3:0] SelMul = 4'b0011;
  localparam logic [3:0] SelDiv = 4'b0100;
  localparam logic [3:0] SelSub = 4'b0110;
  localparam logic [3:0] SelSlt = 4'b0111;
  localparam logic [3:0] SelNop = 4'b1000;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMulBusy = 2'd1,
    StDivBusy = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative datapath: unsigned shift-add multiplier and restoring divider, one
// bit per cycle. Exposes next-state values so the owner can capture the final step.
module alu_muldiv_seq #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             div_i,
  input  logic             busy_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             last_o,
  output logic [Width-1:0] lo_o,
  output logic [Width-1:0] hi_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  logic [Width-1:0] opnd_q, opnd_d;
  logic [Width-1:0] lo_q, lo_d;
  logic [Width-1:0] hi_q, hi_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width:0]   mul_sum, div_shift, div_diff;

  // Multiply: opnd holds the multiplicand, lo the multiplier, hi the partial sum.
  // Divide: opnd holds the divisor, lo the dividend/quotient, hi the remainder.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[Width-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    opnd_d    = opnd_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    if (load_i) begin
      opnd_d = div_i ? b_i : a_i;
      lo_d   = div_i ? a_i : b_i;
      hi_d   = '0;
      cnt_d  = CntW'(Width);
    end else if (busy_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
      if (div_i) begin
        // Top bit of the difference set means the trial subtraction went negative.
        if (!div_diff[Width]) begin
          hi_d = div_diff[Width-1:0];
          lo_d = {lo_q[Width-2:0], 1'b1};
        end else begin
          hi_d = div_shift[Width-1:0];
          lo_d = {lo_q[Width-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {mul_sum, lo_q[Width-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opnd_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      cnt_q  <= '0;
    end else begin
      opnd_q <= opnd_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_o = busy_i && (cnt_q == CntW'(1));
  assign lo_o   = lo_d;
  assign hi_o   = hi_d;

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt/nop plus iterative MUL/DIV,
// with a start/ready/valid handshake for pipeline stalls.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             valid_q, valid_d;

  logic             seq_load, seq_div, seq_last;
  logic [WIDTH-1:0] seq_lo, seq_hi;
  logic [WIDTH-1:0] single_res;

  alu_muldiv_seq #(
    .Width (WIDTH)
  ) u_muldiv (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (seq_load),
    .div_i  (seq_div),
    .busy_i (state_q != StIdle),
    .a_i    (a),
    .b_i    (b),
    .last_o (seq_last),
    .lo_o   (seq_lo),
    .hi_o   (seq_hi)
  );

  // Unlisted encodings fall into the default arm and behave as NOP.
  always_comb begin
    single_res = '0;
    case (sel)
      SelAnd:  single_res = a & b;
      SelOr:   single_res = a | b;
      SelAdd:  single_res = a + b;
      SelSub:  single_res = a - b;
      SelSlt:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    valid_d  = 1'b0;
    seq_load = 1'b0;
    seq_div  = (state_q == StDivBusy);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (sel)
            SelMul: begin
              seq_load = 1'b1;
              state_d  = StMulBusy;
            end
            SelDiv: begin
              seq_div = 1'b1;
              if (b == '0) begin
                result_d = '1;
                hi_d     = a;
                dbz_d    = 1'b1;
                valid_d  = 1'b1;
              end else begin
                seq_load = 1'b1;
                state_d  = StDivBusy;
              end
            end
            default: begin
              result_d = single_res;
              hi_d     = '0;
              dbz_d    = 1'b0;
              valid_d  = 1'b1;
            end
          endcase
        end
      end
      StMulBusy, StDivBusy: begin
        if (seq_last) begin
          result_d = seq_lo;
          hi_d     = seq_hi;
          dbz_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (valid_d) begin
      zero_d = (result_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      valid_q  <= valid_d;
    end
  end

  assign ready       = (state_q == StIdle);
  assign valid       = valid_q;
  assign result      = result_q;
  assign hi          = hi_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and randomized checks of alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready, valid, zero, div_by_zero;
  logic [31:0] result, hi;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  alu_multicycle #(
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sel         (sel),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .valid       (valid),
    .result      (result),
    .hi          (hi),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the op definitions.
  task automatic model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic [31:0] h, output logic dz,
                       output int lat);
    logic [63:0] p;
    r = '0; h = '0; dz = 1'b0; lat = 1;
    case (s)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b0011: begin
        p = {32'b0, x} * {32'b0, y};
        r = p[31:0]; h = p[63:32]; lat = 33;
      end
      4'b0100: begin
        if (y == 0) begin
          r = 32'hFFFF_FFFF; h = x; dz = 1'b1;
        end else begin
          r = x / y; h = x % y; lat = 33;
        end
      end
      default: ;
    endcase
  endtask

  // Issue one op, optionally disturb inputs while busy, and check the completed result.
  task automatic do_op(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                       input string tag, input bit disturb);
    logic [31:0] er, eh;
    logic        edz;
    int          elat, lat, rlow;
    model(s, x, y, er, eh, edz, elat);
    start = 1'b1; sel = s; a = x; b = y;
    tick();
    start = 1'b0;
    lat = 1; rlow = 0;
    while (valid !== 1'b1 && lat < 40) begin
      if (ready === 1'b0) rlow++;
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        sel   = 4'($urandom);
        a     = $urandom;
        b     = $urandom;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " ready_low_cycles"}, 64'(rlow), 64'(elat - 1));
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " zero"}, 64'(zero), 64'(er == 0));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
    check({tag, " ready_at_valid"}, 64'(ready), 64'd1);
    tick();
    check({tag, " valid_one_cycle"}, 64'(valid), 64'd0);
  endtask

  initial begin
    logic [3:0]  codes [10];
    logic [3:0]  bs [4];
    logic [31:0] ba [4], bb [4], exp_b2b [4];
    logic [3:0]  s;
    logic [31:0] x, y;
    bit          saw_valid;

    codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h3, 4'h4, 4'h8, 4'hF, 4'h5};

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset ready", 64'(ready), 64'd1);
    check("reset valid", 64'(valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset zero", 64'(zero), 64'd1);
    check("reset dbz", 64'(div_by_zero), 64'd0);

    // Directed ops
    do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, "add_wrap", 1'b0);
    do_op(4'b0110, 32'd5, 32'd7, "sub", 1'b0);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, "slt_neg", 1'b0);
    do_op(4'b0111, 32'd1, 32'hFFFF_FFFF, "slt_pos", 1'b0);
    do_op(4'b0011, 32'h0001_0000, 32'h0003_0000, "mul", 1'b1);
    do_op(4'b0100, 32'd100, 32'd7, "div", 1'b1);
    do_op(4'b0100, 32'd9, 32'd0, "div0", 1'b0);

    // Reset in the middle of a MUL
    start = 1'b1; sel = 4'b0011; a = 32'd123; b = 32'd456;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst ready", 64'(ready), 64'd1);
    check("midrst valid", 64'(valid), 64'd0);
    check("midrst result", 64'(result), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst zero", 64'(zero), 64'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid === 1'b1) saw_valid = 1'b1;
    end
    check("midrst no_valid", 64'(saw_valid), 64'd0);
    do_op(4'b0010, 32'd2, 32'd3, "add_after_rst", 1'b0);

    // start and rst at the same edge
    rst = 1'b1; start = 1'b1; sel = 4'b0011; a = 32'd7; b = 32'd9;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start ready", 64'(ready), 64'd1);
    tick();
    check("rst_start valid", 64'(valid), 64'd0);

    // Back-to-back single-cycle ops
    bs = '{4'b0000, 4'b0001, 4'b1000, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    exp_b2b[0] = ba[0] & bb[0];
    exp_b2b[1] = ba[1] | bb[1];
    exp_b2b[2] = '0;
    exp_b2b[3] = '0;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; sel = bs[i]; a = ba[i]; b = bb[i];
      tick();
      check($sformatf("b2b%0d valid", i), 64'(valid), 64'd1);
      check($sformatf("b2b%0d result", i), 64'(result), 64'(exp_b2b[i]));
    end
    start = 1'b0;
    tick();
    check("b2b end valid", 64'(valid), 64'd0);

    // Randomized ops
    for (int i = 0; i < 24; i++) begin
      s = codes[$urandom_range(0, 9)];
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if (s == 4'b0100 && $urandom_range(0, 3) == 0) y = '0;
      do_op(s, x, y, $sformatf("rand%0d_sel%0h", i, s), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
